// File: rtl/aes_pkg.sv
// Shared AES definitions: block/word widths, FSM state encoding, Rcon table
// and the combinational round primitives (SubBytes, ShiftRows, MixColumns,
// AddRoundKey) plus the word-level helpers used by the key schedule.
// Byte order everywhere: bits [127:120] of a block are FIPS-197 byte 0,
// bits [31:24] of a word are its byte 0.
package aes_pkg;

   localparam int NB        = 128;
   localparam int BYTE_W    = 8;
   localparam int WORD_W    = 32;
   localparam int NB_BYTES  = NB / BYTE_W;
   localparam int BYTE0_MSB = NB - 1;
   localparam int RCON_LEN  = 10;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [BYTE_W-1:0] byte_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } aes_state_t;

   localparam byte_t RCON [RCON_LEN] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic int nr_from_nk(input int nk);
      return nk + 6;
   endfunction

   // Bit offset of the MSB of byte i inside a block.
   function automatic int byte_msb(input int i);
      return BYTE0_MSB - BYTE_W * i;
   endfunction

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gf_mul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t acc;
      p   = a;
      acc = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         if (b[i]) acc ^= p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // S-box built from the field inverse (a^254) and the affine map, so the
   // table cannot drift from its definition.
   function automatic byte_t sbox(input byte_t a);
      byte_t p;
      byte_t r;
      p = a;
      r = 8'h01;
      for (int i = 1; i < BYTE_W; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [NB-1:0] sub_bytes(input logic [NB-1:0] s);
      logic [NB-1:0] o;
      o = '0;
      for (int i = 0; i < NB_BYTES; i++)
         o[byte_msb(i) -: BYTE_W] = sbox(s[byte_msb(i) -: BYTE_W]);
      return o;
   endfunction

   // Byte (row r, column c) sits at index 4c+r; row r rotates left by r.
   function automatic logic [NB-1:0] shift_rows(input logic [NB-1:0] s);
      logic [NB-1:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[byte_msb(4*c + r) -: BYTE_W] = s[byte_msb(4*((c + r) % 4) + r) -: BYTE_W];
      return o;
   endfunction

   function automatic logic [NB-1:0] mix_columns(input logic [NB-1:0] s);
      logic [NB-1:0] o;
      byte_t         b0, b1, b2, b3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         b0 = s[byte_msb(4*c)     -: BYTE_W];
         b1 = s[byte_msb(4*c + 1) -: BYTE_W];
         b2 = s[byte_msb(4*c + 2) -: BYTE_W];
         b3 = s[byte_msb(4*c + 3) -: BYTE_W];
         o[byte_msb(4*c)     -: BYTE_W] = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
         o[byte_msb(4*c + 1) -: BYTE_W] = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
         o[byte_msb(4*c + 2) -: BYTE_W] = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
         o[byte_msb(4*c + 3) -: BYTE_W] = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
      end
      return o;
   endfunction

   function automatic logic [NB-1:0] add_round_key(input logic [NB-1:0] s,
                                                   input logic [NB-1:0] rk);
      return s ^ rk;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of on-the-fly key expansion: from the window w[j-NK .. j-1]
// produce w[j .. j+3]. Within any 4-word step at most one word needs a
// non-identity f, so only two SubWord paths exist (rotated+Rcon, plain);
// everything else is an XOR chain.
module aes_key_step
   import aes_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic [WORD_W*NK-1:0] win,
   input  logic [5:0]           j,
   output logic [NB-1:0]        next_words
);

   word_t      w [NK];
   logic       hit;
   logic       rot;
   logic [1:0] sel;
   byte_t      rcon_b;
   word_t      d_in;
   word_t      sw_rot;
   word_t      sw_plain;

   // Unpack the window; w[0] is the oldest word.
   always_comb begin
      for (int i = 0; i < NK; i++)
         w[i] = win[WORD_W*(NK-1-i) +: WORD_W];
   end

   // Find the step position needing SubWord, and its Rcon.
   always_comb begin
      int jj;
      int ridx;
      hit = 1'b0;
      rot = 1'b0;
      sel = '0;
      for (int k = 0; k < 4; k++) begin
         jj = int'(j) + k;
         if (jj % NK == 0) begin
            hit = 1'b1;
            rot = 1'b1;
            sel = 2'(k);
         end else if (NK == 8 && jj % 8 == 4) begin
            hit = 1'b1;
            rot = 1'b0;
            sel = 2'(k);
         end
      end
      ridx   = (int'(j) + int'(sel)) / NK - 1;
      rcon_b = (ridx >= 0 && ridx < RCON_LEN) ? RCON[ridx[3:0]] : 8'h00;
   end

   // Word preceding the special position; the chain before it is pure XOR.
   always_comb begin
      word_t prev;
      prev = w[NK-1];
      d_in = prev;
      for (int k = 0; k < 4; k++) begin
         if (2'(k) == sel) d_in = prev;
         prev = w[k] ^ prev;
      end
   end

   assign sw_rot   = sub_word(rot_word(d_in)) ^ {rcon_b, 24'h000000};
   assign sw_plain = sub_word(d_in);

   // Generate the four new words in order.
   always_comb begin
      word_t prev;
      word_t f;
      word_t nw;
      next_words = '0;
      prev       = w[NK-1];
      for (int k = 0; k < 4; k++) begin
         f = prev;
         if (hit && 2'(k) == sel) f = rot ? sw_rot : sw_plain;
         nw   = w[k] ^ f;
         next_words[NB-1-WORD_W*k -: WORD_W] = nw;
         prev = nw;
      end
   end

endmodule

// File: rtl/aes_cipher_hs.sv
// Iterative AES encryptor, one round per clock, key length set by NK (4/6/8).
// Valid/ready on both sides; the result is held in DONE until accepted, and a
// new block may be loaded on the retire edge.
// Optional: define AES_BLKCNT_EN to add the blk_cnt retired-block counter.
//
// state | meaning
// IDLE  | waiting for a block, in_ready=1
// RUN   | one round per edge, round 0 .. NR
// DONE  | cipher_text valid, held until out_ready
module aes_cipher_hs
   import aes_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NB-1:0]       plain_text,
   input  logic [WORD_W*NK-1:0] key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NB-1:0]       cipher_text,
`ifdef AES_BLKCNT_EN
   output logic [31:0]         blk_cnt,
`endif
   output logic                busy
);

   localparam int         NR         = nr_from_nk(NK);
   localparam logic [3:0] LAST_ROUND = 4'(NR);

   generate
      if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_illegal
         $error("aes_cipher_hs: NK must be 4, 6 or 8");
      end
   endgenerate

   aes_state_t           cur;
   aes_state_t           nxt;
   logic [NB-1:0]        blk;
   logic [WORD_W*NK-1:0] win;
   logic [WORD_W*NK-1:0] win_next;
   logic [NB-1:0]        key_words;
   logic [NB-1:0]        rk;
   logic [NB-1:0]        round_x;
   logic [3:0]           round;
   logic [5:0]           j;
   logic                 load;

   aes_key_step #(.NK(NK)) u_key_step (
      .win        (win),
      .j          (j),
      .next_words (key_words)
   );

   assign rk = win[WORD_W*NK-1 -: NB];

   generate
      if (NK == 4) begin : g_win_nk4
         assign win_next = key_words;
      end else begin : g_win_wide
         assign win_next = {win[WORD_W*NK-NB-1:0], key_words};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cur <= ST_IDLE;
      else       cur <= nxt;
   end

   // Next state and handshake outputs.
   always_comb begin
      nxt       = cur;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (cur)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (round == LAST_ROUND) nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) nxt = in_valid ? ST_RUN : ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   assign load        = in_valid & in_ready;
   assign cipher_text = (cur == ST_DONE) ? blk : '0;

   // Round transform feeding AddRoundKey.
   always_comb begin
      logic [NB-1:0] sr;
      sr = shift_rows(sub_bytes(blk));
      if (round == 4'd0)            round_x = blk;
      else if (round == LAST_ROUND) round_x = sr;
      else                          round_x = mix_columns(sr);
   end

   // Datapath: load on handshake, one round plus one key step per RUN edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         blk   <= '0;
         win   <= '0;
         round <= '0;
         j     <= '0;
      end else if (load) begin
         blk   <= plain_text;
         win   <= key;
         round <= '0;
         j     <= 6'(NK);
      end else if (cur == ST_RUN) begin
         blk   <= add_round_key(round_x, rk);
         win   <= win_next;
         round <= round + 4'd1;
         j     <= j + 6'd4;
      end
   end

`ifdef AES_BLKCNT_EN
   // Count retired blocks; survives returns to IDLE, wraps naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                       blk_cnt <= '0;
      else if (out_valid && out_ready) blk_cnt <= blk_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_aes_cipher_hs.sv
// Directed bench for aes_cipher_hs: one instance per key length, FIPS-197
// vectors, latency, backpressure with zero-bubble reload, and mid-RUN reset.
// Define AES_BLKCNT_EN to also exercise blk_cnt.
module tb_aes_cipher_hs;

   localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C4   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C6   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C8   = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic         clk;
   logic         rstn;
   logic [2:0]   in_valid;
   logic [2:0]   out_ready;
   logic [127:0] pt;
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;

   logic         ir4, ir6, ir8, ov4, ov6, ov8, bz4, bz6, bz8;
   logic [127:0] ct4, ct6, ct8;
   logic [2:0]   in_ready, out_valid, busy;
   logic [2:0][127:0] ct;
`ifdef AES_BLKCNT_EN
   logic [31:0]  cnt4, cnt6, cnt8;
`endif

   int n_cmp = 0;
   int n_err = 0;

   assign in_ready  = {ir8, ir6, ir4};
   assign out_valid = {ov8, ov6, ov4};
   assign busy      = {bz8, bz6, bz4};
   assign ct        = {ct8, ct6, ct4};

   aes_cipher_hs #(.NK(4)) u_nk4 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid[0]), .in_ready(ir4),
      .plain_text(pt), .key(key4), .out_valid(ov4), .out_ready(out_ready[0]),
      .cipher_text(ct4),
`ifdef AES_BLKCNT_EN
      .blk_cnt(cnt4),
`endif
      .busy(bz4));

   aes_cipher_hs #(.NK(6)) u_nk6 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid[1]), .in_ready(ir6),
      .plain_text(pt), .key(key6), .out_valid(ov6), .out_ready(out_ready[1]),
      .cipher_text(ct6),
`ifdef AES_BLKCNT_EN
      .blk_cnt(cnt6),
`endif
      .busy(bz6));

   aes_cipher_hs #(.NK(8)) u_nk8 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid[2]), .in_ready(ir8),
      .plain_text(pt), .key(key8), .out_valid(ov8), .out_ready(out_ready[2]),
      .cipher_text(ct8),
`ifdef AES_BLKCNT_EN
      .blk_cnt(cnt8),
`endif
      .busy(bz8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_inputs(input logic [255:0] k, input logic [127:0] p);
      pt   = p;
      key4 = k[255:128];
      key6 = k[255:64];
      key8 = k;
   endtask

   task automatic start_block(input int idx, input logic [255:0] k,
                              input logic [127:0] p, input string tag);
      @(negedge clk);
      set_inputs(k, p);
      in_valid[idx] = 1'b1;
      chk({tag, "_in_ready"}, 256'(in_ready[idx]), 256'(1));
      @(posedge clk);
      #1;
      in_valid[idx] = 1'b0;
      chk({tag, "_busy"}, 256'({busy[idx], in_ready[idx]}), 256'(2'b10));
   endtask

   // Counts edges from the accepting edge until out_valid rises.
   task automatic wait_result(input int idx, input int exp_lat,
                              input logic [127:0] exp_ct, input string tag);
      int lat;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!out_valid[idx] && lat < 40);
      chk({tag, "_latency"}, 256'(lat), 256'(exp_lat));
      chk({tag, "_ct"}, 256'(ct[idx]), 256'(exp_ct));
   endtask

   task automatic retire(input int idx, input string tag);
      @(negedge clk);
      out_ready[idx] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[idx] = 1'b0;
      chk({tag, "_retired"}, 256'({out_valid[idx], in_ready[idx]}), 256'(2'b01));
   endtask

   initial begin
      rstn      = 1'b0;
      in_valid  = '0;
      out_ready = '0;
      set_inputs('0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_nk4", 256'({out_valid[0], busy[0], in_ready[0], ct[0]}), {127'h0, 1'b1, 128'h0});
      chk("reset_nk8", 256'({out_valid[2], busy[2], in_ready[2], ct[2]}), {127'h0, 1'b1, 128'h0});
      @(negedge clk);
      rstn = 1'b1;

      // FIPS-197 App B.
      start_block(0, KEY_B, PT_B, "appb");
      wait_result(0, 11, CT_B, "appb");
      retire(0, "appb");

      // App C.1; inputs change and in_valid is raised during RUN, all ignored.
      start_block(0, KEY_SEQ, PT_C, "c1");
      set_inputs({128'hdeadbeefdeadbeefdeadbeefdeadbeef, 128'h0}, 128'hffffffffffffffffffffffffffffffff);
      in_valid[0] = 1'b1;
      wait_result(0, 11, CT_C4, "c1");
      in_valid[0] = 1'b0;
      retire(0, "c1");

      start_block(1, KEY_SEQ, PT_C, "c2");
      wait_result(1, 13, CT_C6, "c2");
      retire(1, "c2");

      start_block(2, KEY_SEQ, PT_C, "c3");
      wait_result(2, 15, CT_C8, "c3");
      retire(2, "c3");

      // Backpressure then zero-bubble reload, from a fresh reset.
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
`ifdef AES_BLKCNT_EN
      chk("blk_cnt_reset", 256'(cnt4), 256'(0));
`endif
      start_block(0, KEY_SEQ, PT_C, "bp");
      wait_result(0, 11, CT_C4, "bp");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold", 256'({out_valid[0], in_ready[0], ct[0]}), 256'({1'b1, 1'b0, CT_C4}));
      end
      @(negedge clk);
      out_ready[0] = 1'b1;
      set_inputs(KEY_B, PT_B);
      in_valid[0] = 1'b1;
      #1;
      chk("b2b_in_ready", 256'(in_ready[0]), 256'(1));
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b0;
      chk("b2b_loaded", 256'({out_valid[0], busy[0]}), 256'(2'b01));
      wait_result(0, 11, CT_B, "b2b");
      retire(0, "b2b");
`ifdef AES_BLKCNT_EN
      chk("blk_cnt_two", 256'(cnt4), 256'(2));
`endif

      // Reset during round 5 aborts without emitting a result.
      start_block(0, KEY_B, PT_B, "rmid");
      repeat (5) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk("rmid_outputs", 256'({out_valid[0], busy[0], in_ready[0], ct[0]}), {127'h0, 1'b1, 128'h0});
      @(negedge clk);
      rstn = 1'b1;
      start_block(0, KEY_B, PT_B, "rpost");
      wait_result(0, 11, CT_B, "rpost");
      retire(0, "rpost");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
